toy_processor: RTL and testbench
================================

Name: toy_processor

Overview:
- Minimal 8-bit accumulator processor with a fixed six-state cycle: fetch opcode, fetch operand, execute, optional write-back.
- Talks to an external byte-wide memory through ADD, D_IN, D_OUT, MEM_EN and RORW.
- Drives a one-hot state indicator (S0..S5) for bring-up and debug.
- Sits at top level on the lab board; memory is external.

Parameters:
- PC_RESET, 8'h00, program counter value loaded on reset.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- D_IN  in  8  read data from memory.
- D_OUT  out  8  write data to memory; always equals ACC.
- ADD  out  8  memory address.
- MEM_EN  out  1  memory enable; 1 = access this cycle.
- RORW  out  1  1 = read, 0 = write; meaningful only when MEM_EN = 1.
- S0..S5  out  1 each  one-hot current-state indicators.

Behaviour:
- Registers: PC[7:0], IR[7:0], OPR[7:0], ACC[7:0], STATE (one-hot, six states).
- Reset asserted (RESET = 0), immediately and regardless of clock:
  - STATE = S0, PC = PC_RESET, IR = OPR = ACC = 0.
  - Resulting outputs: S0 = 1 and S1..S5 = 0, ADD = PC_RESET, MEM_EN = 1, RORW = 1, D_OUT = 0.
  - Reset mid-instruction aborts the instruction; no partial write-back.
- Outputs are decoded combinationally from STATE and the registers. Every state is exactly one cycle.
- S0 FETCH_A: ADD = PC, MEM_EN = 1, RORW = 1. Next state S1.
- S1 FETCH_B: same outputs as S0. On the exit edge, IR <= D_IN and PC <= PC + 1 (wraps FF -> 00). Next state S2.
- S2 OPND_A: ADD = PC, MEM_EN = 1, RORW = 1. Next state S3.
- S3 OPND_B: same outputs as S2. On the exit edge, OPR <= D_IN and PC <= PC + 1 (wraps). Next state S4.
- S4 EXEC: MEM_EN = 0, ADD = OPR. Decode IR:
  - 0x01 LDI: ACC <= OPR.
  - 0x02 ADDI: ACC <= ACC + OPR, modulo 256; carry discarded.
  - 0x04 STA: no register change; next state S5.
  - 0x08 ANDI: ACC <= ACC & OPR.
  - 0x10 JMP: PC <= OPR.
  - Any other value: NOP.
  - Next state is S5 for STA and S0 for all other opcodes.
- S5 WRITE: ADD = OPR, D_OUT = ACC, MEM_EN = 1, RORW = 0. Next state S0.
- Instruction timing: every instruction is 5 cycles, except STA which is 6.
- D_IN is sampled only on the S1 and S3 exit edges; it is ignored in all other states.
- Illegal STATE encoding (not one-hot) recovers to S0 on the next edge.

Optional Feature:
- Macro TOYPROC_BRZ_EN.
- When defined: adds a Z flag, set when ACC == 0 and updated on every ACC write, reset to 1. Adds opcode 0x20 BRZ: in S4, PC <= OPR if Z = 1, else no change.
- When not defined: 0x20 is a NOP and no Z flag exists.

Decomposition:
- Package toy_processor_pkg:
  - one-hot state constants S0..S5;
  - opcode constants OP_LDI, OP_ADDI, OP_STA, OP_ANDI, OP_JMP, OP_BRZ;
  - the state typedef.
- One sub-module, toy_alu: combinational; inputs ACC, OPR, IR; outputs next ACC and, under TOYPROC_BRZ_EN, the zero flag.
- Sequencer and output decode remain in toy_processor.

Test Plan:
- Reset: hold RESET = 0 for 2 cycles -> S0 = 1, ADD = 00, MEM_EN = 1, RORW = 1, D_OUT = 00. Release -> S0..S5 advance one per cycle.
- LDI: D_IN = 01 during S1, AA during S3 -> after S4, D_OUT = AA. ADD sequence 00, 00, 01, 01; next fetch at ADD = 02.
- STA: after LDI FE, STA operand 08 -> S5 with ADD = 08, D_OUT = FE, MEM_EN = 1, RORW = 0; next state S0.
- ADDI wrap: ACC = FF, ADDI 01 -> ACC = 00. ANDI: ACC = CC, ANDI 0F -> ACC = 0C.
- JMP: JMP 10 -> next S0 shows ADD = 10. PC wrap: an opcode fetched at FF -> PC = 00, so the operand is fetched from address 00.
- Mid-instruction reset: assert RESET in S3 -> outputs return to reset values immediately, with no S5 write.

Source files
------------

// File: rtl/toy_processor_pkg.sv
// Shared definitions for the toy accumulator processor: one-hot states and opcodes.
package toy_processor_pkg;

  typedef enum logic [5:0] {
    ST_FETCH_A = 6'b000001,
    ST_FETCH_B = 6'b000010,
    ST_OPND_A  = 6'b000100,
    ST_OPND_B  = 6'b001000,
    ST_EXEC    = 6'b010000,
    ST_WRITE   = 6'b100000
  } state_t;

  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_ADDI = 8'h02;
  localparam logic [7:0] OP_STA  = 8'h04;
  localparam logic [7:0] OP_ANDI = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_BRZ  = 8'h20;

endpackage

// File: rtl/toy_alu.sv
// Combinational accumulator update; zero flag output exists only under TOYPROC_BRZ_EN.
module toy_alu
  import toy_processor_pkg::*;
(
  input  logic [7:0] i_acc,
  input  logic [7:0] i_opr,
  input  logic [7:0] i_ir,
`ifdef TOYPROC_BRZ_EN
  output logic       o_zero,
`endif
  output logic [7:0] o_acc_nxt
);

  always_comb begin
    o_acc_nxt = i_acc;
    case (i_ir)
      OP_LDI:  o_acc_nxt = i_opr;
      OP_ADDI: o_acc_nxt = i_acc + i_opr;
      OP_ANDI: o_acc_nxt = i_acc & i_opr;
      default: o_acc_nxt = i_acc;
    endcase
  end

`ifdef TOYPROC_BRZ_EN
  assign o_zero = (o_acc_nxt == '0);
`endif

endmodule

// File: rtl/toy_processor.sv
// Six-state 8-bit accumulator processor with external byte memory.
// Define TOYPROC_BRZ_EN to add the Z flag and the BRZ (0x20) opcode.
module toy_processor
  import toy_processor_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic [7:0] ADD,
  output logic       MEM_EN,
  output logic       RORW,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic       S5
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, r_ir, r_opr, r_acc;
  logic [7:0] w_acc_nxt;
`ifdef TOYPROC_BRZ_EN
  logic       r_z, w_zero;
`endif

  toy_alu u_alu (
    .i_acc     (r_acc),
    .i_opr     (r_opr),
    .i_ir      (r_ir),
`ifdef TOYPROC_BRZ_EN
    .o_zero    (w_zero),
`endif
    .o_acc_nxt (w_acc_nxt)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_FETCH_A;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc  <= PC_RESET;
      r_ir  <= '0;
      r_opr <= '0;
      r_acc <= '0;
`ifdef TOYPROC_BRZ_EN
      r_z   <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_FETCH_B: begin
          r_ir <= D_IN;
          r_pc <= r_pc + 8'd1;
        end
        ST_OPND_B: begin
          r_opr <= D_IN;
          r_pc  <= r_pc + 8'd1;
        end
        ST_EXEC: begin
          // ALU passes ACC through for non-arithmetic opcodes, so Z stays consistent.
          r_acc <= w_acc_nxt;
`ifdef TOYPROC_BRZ_EN
          r_z   <= w_zero;
          if (r_ir == OP_JMP || (r_ir == OP_BRZ && r_z)) r_pc <= r_opr;
`else
          if (r_ir == OP_JMP) r_pc <= r_opr;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = ST_FETCH_A;
    ADD         = r_pc;
    MEM_EN      = 1'b1;
    RORW        = 1'b1;
    case (r_state)
      ST_FETCH_A: w_state_nxt = ST_FETCH_B;
      ST_FETCH_B: w_state_nxt = ST_OPND_A;
      ST_OPND_A:  w_state_nxt = ST_OPND_B;
      ST_OPND_B:  w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        ADD         = r_opr;
        MEM_EN      = 1'b0;
        w_state_nxt = (r_ir == OP_STA) ? ST_WRITE : ST_FETCH_A;
      end
      ST_WRITE: begin
        ADD  = r_opr;
        RORW = 1'b0;
      end
      default: w_state_nxt = ST_FETCH_A;
    endcase
  end

  assign {S5, S4, S3, S2, S1, S0} = r_state;
  assign D_OUT = r_acc;

endmodule

// File: tb/tb_toy_processor.sv
// Self-checking bench for toy_processor: instruction table, random programs, mid-instruction reset.
module tb_toy_processor;

  logic       CLK, RESET;
  logic [7:0] D_IN, D_OUT, ADD;
  logic       MEM_EN, RORW, S0, S1, S2, S3, S4, S5;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Instruction-level reference state.
  logic [7:0] m_pc, m_acc;
  logic       m_z;

  typedef struct {
    logic [7:0] op;
    logic [7:0] opr;
    logic [7:0] exp_acc;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  toy_processor #(.PC_RESET(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .D_IN(D_IN), .D_OUT(D_OUT), .ADD(ADD),
    .MEM_EN(MEM_EN), .RORW(RORW),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] states();
    return {2'b00, S5, S4, S3, S2, S1, S0};
  endfunction

  task automatic model_reset();
    m_pc  = 8'h00;
    m_acc = 8'h00;
    m_z   = 1'b1;
  endtask

  task automatic model_exec(input logic [7:0] op, input logic [7:0] opr);
    m_pc = m_pc + 8'd2;
    case (op)
      8'h01: begin m_acc = opr;         m_z = (m_acc == 8'h00); end
      8'h02: begin m_acc = m_acc + opr; m_z = (m_acc == 8'h00); end
      8'h08: begin m_acc = m_acc & opr; m_z = (m_acc == 8'h00); end
      8'h10: m_pc = opr;
`ifdef TOYPROC_BRZ_EN
      8'h20: if (m_z) m_pc = opr;
`endif
      default: ;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, states(), 8'h01);
    chk({tag, "_add"}, ADD, 8'h00);
    chk({tag, "_mem_en"}, {7'b0, MEM_EN}, 8'h01);
    chk({tag, "_rorw"}, {7'b0, RORW}, 8'h01);
    chk({tag, "_dout"}, D_OUT, 8'h00);
  endtask

  // Called with DUT in S0 just after a negedge; leaves it in the next S0.
  // abort_at >= 0 asserts reset while in that state.
  task automatic run_instr(input logic [7:0] op, input logic [7:0] opr, input int abort_at);
    int unsigned ncyc;
    logic [7:0]  exp_add;
    logic [7:0]  pc_op;
    ncyc  = (op == 8'h04) ? 6 : 5;
    pc_op = m_pc;
    for (int unsigned k = 0; k < ncyc; k++) begin
      if (k < 2)      exp_add = pc_op;
      else if (k < 4) exp_add = pc_op + 8'd1;
      else            exp_add = opr;
      chk("cyc_state", states(), 8'(1 << k));
      chk("cyc_add", ADD, exp_add);
      chk("cyc_mem_en", {7'b0, MEM_EN}, (k == 4) ? 8'h00 : 8'h01);
      if (k != 4) chk("cyc_rorw", {7'b0, RORW}, (k == 5) ? 8'h00 : 8'h01);
      chk("cyc_dout", D_OUT, m_acc);
      if (int'(k) == abort_at) begin
        RESET = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        return;
      end
      if (k == 1)      D_IN = op;
      else if (k == 3) D_IN = opr;
      else             D_IN = 8'($urandom);
      @(posedge CLK);
      @(negedge CLK);
    end
    model_exec(op, opr);
  endtask

  initial begin
    RESET = 1'b0;
    D_IN  = 8'h00;
    model_reset();

    // Table of instructions run back to back from reset.
    vecs.push_back('{8'h01, 8'hAA, 8'hAA, 8'h02});
    vecs.push_back('{8'h01, 8'hFE, 8'hFE, 8'h04});
    vecs.push_back('{8'h04, 8'h08, 8'hFE, 8'h06});
    vecs.push_back('{8'h01, 8'hFF, 8'hFF, 8'h08});
    vecs.push_back('{8'h02, 8'h01, 8'h00, 8'h0A});
    vecs.push_back('{8'h01, 8'hCC, 8'hCC, 8'h0C});
    vecs.push_back('{8'h08, 8'h0F, 8'h0C, 8'h0E});
    vecs.push_back('{8'h40, 8'h33, 8'h0C, 8'h10});
    vecs.push_back('{8'h10, 8'h10, 8'h0C, 8'h10});
    vecs.push_back('{8'h10, 8'hFF, 8'h0C, 8'hFF});
    vecs.push_back('{8'h01, 8'h5A, 8'h5A, 8'h01});
    vecs.push_back('{8'h02, 8'hA6, 8'h00, 8'h03});
`ifdef TOYPROC_BRZ_EN
    vecs.push_back('{8'h20, 8'h40, 8'h00, 8'h40});
`else
    vecs.push_back('{8'h20, 8'h40, 8'h00, 8'h05});
`endif

    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    RESET = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].opr, -1);
      chk("row_acc", D_OUT, vecs[i].exp_acc);
      chk("row_pc", ADD, vecs[i].exp_pc);
    end

    // Reset during S3 of a store: no write cycle may follow.
    run_instr(8'h01, 8'h77, -1);
    run_instr(8'h04, 8'h30, 3);
    check_reset_outputs("post_rst");
    run_instr(8'h01, 8'h12, -1);
    chk("post_rst_acc", D_OUT, 8'h12);

    for (int n = 0; n < 80; n++) begin
      logic [7:0] op;
      case ($urandom_range(0, 6))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h04;
        3: op = 8'h08;
        4: op = 8'h10;
        5: op = 8'h20;
        default: op = 8'($urandom);
      endcase
      run_instr(op, 8'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
